// File: rtl/instr_loader.sv
// Byte-stream program loader: packs big-endian bytes into 32-bit words, writes imem, then releases CPU reset.
// Optional INSTR_LOADER_CHECKSUM_EN: trailing 4-byte checksum compared against the wrap-around sum of written words.
module instr_loader #(
    parameter int DEPTH_WORDS = 256,
    parameter int LEN_W       = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_data_i,
    output logic             byte_ready_o,
    output logic             imem_we_o,
    output logic [31:0]      imem_addr_o,
    output logic [31:0]      imem_data_o,
    output logic             cpu_rst_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERROR,
        S_CKSUM
    } state_t;

    localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

    state_t           state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [LEN_W-1:0] word_idx_q, word_idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      asm_q, asm_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic             ready_q, ready_d;
    logic             we_q, we_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [31:0]      sum_q, sum_d;
`endif

    logic             accept;
    assign accept = byte_valid_i & ready_q;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        len_d      = len_q;
        asm_d      = asm_q;
        addr_d     = addr_q;
        data_d     = data_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    byte_cnt_d = 2'd0;
                    word_idx_d = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    sum_d      = 32'd0;
`endif
                    if (len_i == '0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        state_d = S_CKSUM;
`else
                        state_d = S_DONE;
`endif
                    end else if (32'(len_i) > DEPTH_U) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_LOAD;
                        len_d   = len_i;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    asm_d      = {asm_q[23:0], byte_data_i};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        addr_d  = 32'(word_idx_q) << 2;
                        data_d  = asm_d;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + LEN_W'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
                sum_d      = sum_q + data_q;
                state_d    = (word_idx_d == len_q) ? S_CKSUM : S_LOAD;
`else
                state_d    = (word_idx_d == len_q) ? S_DONE : S_LOAD;
`endif
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CKSUM: begin
                if (accept) begin
                    asm_d      = {asm_q[23:0], byte_data_i};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = (asm_d == sum_q) ? S_DONE : S_ERROR;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered yet aligned with the state.
        ready_d   = (state_d == S_LOAD) || (state_d == S_CKSUM);
        we_d      = (state_d == S_WRITE);
        cpu_rst_d = (state_d == S_DONE);
        busy_d    = (state_d == S_LOAD) || (state_d == S_WRITE) || (state_d == S_CKSUM);
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_ERROR);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            word_idx_q <= '0;
            len_q      <= '0;
            asm_q      <= 32'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            cpu_rst_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_q      <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            len_q      <= len_d;
            asm_q      <= asm_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign byte_ready_o = ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_data_o  = data_q;
    assign cpu_rst_o    = cpu_rst_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected imem writes queued by each test, consumed by a write monitor.
module tb_instr_loader;

    localparam int DEPTH = 256;
    localparam int LW    = 9;
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam int CK_EXTRA = 4;
`else
    localparam int CK_EXTRA = 0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [LW-1:0] len_i;
    logic          byte_valid_i;
    logic [7:0]    byte_data_i;
    logic          byte_ready_o;
    logic          imem_we_o;
    logic [31:0]   imem_addr_o;
    logic [31:0]   imem_data_o;
    logic          cpu_rst_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  tx_q[$];

    instr_loader #(.DEPTH_WORDS(DEPTH), .LEN_W(LW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
        .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
        .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
        .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // Write monitor: every strobe must match the oldest expected write, with byte_ready low.
    always @(negedge clk_i) begin
        if (imem_we_o === 1'b1) begin
            logic [63:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h expected none", imem_addr_o, imem_data_o);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr_o, imem_data_o} !== e) begin
                    errors++;
                    $display("FAIL write addr=%h data=%h expected addr=%h data=%h",
                             imem_addr_o, imem_data_o, e[63:32], e[31:0]);
                end
            end
            checks++;
            if (byte_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_write got=%b expected=0", byte_ready_o);
            end
        end
    end

    task automatic load_prog();
        tx_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h01, 8'h00, 8'h04};
    endtask

    task automatic expect_words(input int base);
        for (int w = 0; w < tx_q.size() / 4; w++)
            exp_q.push_back({32'((base + w) * 4), tx_q[4*w], tx_q[4*w+1], tx_q[4*w+2], tx_q[4*w+3]});
    endtask

    task automatic add_cksum();
`ifdef INSTR_LOADER_CHECKSUM_EN
        logic [31:0] s;
        s = 32'd0;
        for (int w = 0; w < tx_q.size() / 4; w++)
            s = s + {tx_q[4*w], tx_q[4*w+1], tx_q[4*w+2], tx_q[4*w+3]};
        tx_q.push_back(s[31:24]); tx_q.push_back(s[23:16]);
        tx_q.push_back(s[15:8]);  tx_q.push_back(s[7:0]);
`endif
    endtask

    task automatic pulse_start(input int l);
        @(negedge clk_i);
        start_i = 1'b1;
        len_i   = LW'(l);
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Called at a negedge; byte_ready is registered so its value now holds at the next posedge.
    task automatic send(input bit gap);
        int i = 0;
        int slot = 0;
        while (i < tx_q.size() && slot < 400) begin
            if (gap && slot[0]) begin
                byte_valid_i = 1'b0;
            end else begin
                byte_valid_i = 1'b1;
                byte_data_i  = tx_q[i];
                if (byte_ready_o) i++;
            end
            slot++;
            @(negedge clk_i);
        end
        byte_valid_i = 1'b0;
        checks++;
        if (i != tx_q.size()) begin
            errors++;
            $display("FAIL send_timeout sent=%0d expected=%0d", i, tx_q.size());
        end
    endtask

    task automatic wait_done_and_drain(input string name);
        int n = 0;
        while (done_o !== 1'b1 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (done_o !== 1'b1 || cpu_rst_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_done done=%b cpu_rst=%b expected 1 1", name, done_o, cpu_rst_o);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_writes pending=%0d expected=0", name, exp_q.size());
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({byte_ready_o, imem_we_o, imem_addr_o, imem_data_o, cpu_rst_o, busy_o, done_o, err_o} !== 70'd0) begin
            errors++;
            $display("FAIL %s rdy=%b we=%b addr=%h data=%h cpu_rst=%b busy=%b done=%b err=%b expected all 0",
                     name, byte_ready_o, imem_we_o, imem_addr_o, imem_data_o, cpu_rst_o, busy_o, done_o, err_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0; start_i = 1'b0; len_i = '0; byte_valid_i = 1'b0; byte_data_i = 8'h00;
        repeat (3) @(negedge clk_i);
        check_idle_outputs("reset_state");
        rst_i = 1'b1;
        @(negedge clk_i);
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_basic();
        int cnt = 1;
        load_prog();
        expect_words(0);
        add_cksum();
        pulse_start(2);
        checks++;
        if (busy_o !== 1'b1 || byte_ready_o !== 1'b1 || cpu_rst_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_load_entry busy=%b rdy=%b cpu_rst=%b expected 1 1 0", busy_o, byte_ready_o, cpu_rst_o);
        end
        fork
            send(1'b0);
            while (cpu_rst_o !== 1'b1 && cnt < 60) begin
                @(negedge clk_i);
                cnt++;
            end
        join
        checks++;
        if (cnt != 11 + CK_EXTRA) begin
            errors++;
            $display("FAIL basic_release_cycle got=%0d expected=%0d", cnt, 11 + CK_EXTRA);
        end
        wait_done_and_drain("basic");
        checks++;
        if (busy_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_flags busy=%b err=%b expected 0 0", busy_o, err_o);
        end
    endtask

    task automatic test_gapped();
        load_prog();
        expect_words(0);
        add_cksum();
        pulse_start(2);
        checks++;
        if (cpu_rst_o !== 1'b0) begin
            errors++;
            $display("FAIL gapped_cpu_rst_drop got=%b expected=0", cpu_rst_o);
        end
        send(1'b1);
        wait_done_and_drain("gapped");
    endtask

    task automatic test_reload();
        tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        expect_words(0);
        add_cksum();
        pulse_start(1);
        checks++;
        if (cpu_rst_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL reload_entry cpu_rst=%b done=%b busy=%b expected 0 0 1", cpu_rst_o, done_o, busy_o);
        end
        send(1'b0);
        wait_done_and_drain("reload");
    endtask

    task automatic test_bad_len();
        pulse_start(DEPTH + 1);
        checks++;
        if (err_o !== 1'b1 || cpu_rst_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL bad_len err=%b cpu_rst=%b busy=%b done=%b expected 1 0 0 0", err_o, cpu_rst_o, busy_o, done_o);
        end
        repeat (3) @(negedge clk_i);
        checks++;
        if (err_o !== 1'b1 || byte_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bad_len_hold err=%b rdy=%b expected 1 0", err_o, byte_ready_o);
        end
    endtask

    task automatic test_reset_mid_load();
        load_prog();
        void'(tx_q.pop_back()); void'(tx_q.pop_back());
        expect_words(0);
        pulse_start(2);
        send(1'b0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_idle_outputs("reset_mid_load");
        rst_i = 1'b1;
        repeat (6) @(negedge clk_i);
        checks++;
        if (exp_q.size() != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_load_writes pending=%0d busy=%b expected 0 0", exp_q.size(), busy_o);
        end
    endtask

    task automatic test_len_zero();
        pulse_start(0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        tx_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        checks++;
        if (byte_ready_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL len_zero_cksum_wait rdy=%b done=%b expected 1 0", byte_ready_o, done_o);
        end
        send(1'b0);
`endif
        wait_done_and_drain("len_zero");
    endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        tx_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
        exp_q.push_back({32'h0, 32'h0000_0001});
        pulse_start(1);
        send(1'b0);
        wait_done_and_drain("cksum_good");
        tx_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
        exp_q.push_back({32'h0, 32'h0000_0001});
        pulse_start(1);
        send(1'b0);
        @(negedge clk_i);
        checks++;
        if (err_o !== 1'b1 || cpu_rst_o !== 1'b0 || done_o !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL cksum_bad err=%b cpu_rst=%b done=%b pending=%0d expected 1 0 0 0",
                     err_o, cpu_rst_o, done_o, exp_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_reload();
        test_bad_len();
        test_reset_mid_load();
        test_len_zero();
`ifdef INSTR_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (4) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
